bus_mem_responder: RTL and testbench

- Responder (slave) end of the CPU core's BUS_* memory interface: a word-organised RAM behind a valid/ready handshake.
- Adds a programmable number of wait states so initiator stall paths get exercised.
- Sits outside the CPU core; it is the instruction/data memory model on the system bus and the bench target for the core's bus controller.

---
 rtl/bus_mem_responder.sv | 116 +++++++++++
 tb/tb_bus_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - word RAM responder on the BUS_* valid/ready interface
// Inserts WAIT_CYCLES wait states between request acceptance and the write ack / read data.
module bus_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  input  logic        BUS_mode,
  input  logic        BUS_valid,
  output logic        BUS_wready,
  output logic        BUS_rvalid,
  input  logic        BUS_rready,
  output logic [31:0] BUS_rdata,
  output logic        oor_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_WRESP, S_RRESP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [29:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              mode_q;
  logic              latch, wr_resp, rd_resp, rd_accept;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              unused_addr_bits;

  // Byte-lane bits carry no meaning for a word-organised memory.
  assign unused_addr_bits = ^BUS_addr[1:0];
  assign idx              = addr_q[ADDR_W-1:0];
  assign in_range         = (addr_q[29:ADDR_W] == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch     = 1'b0;
    wr_resp   = 1'b0;
    rd_resp   = 1'b0;
    rd_accept = 1'b0;
    case (state)
      S_IDLE: begin
        if (BUS_valid) begin
          latch     = 1'b1;
          cnt_nxt   = 4'(WAIT_CYCLES);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!BUS_valid) begin
          state_nxt = S_IDLE;
        end else if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (mode_q) begin
          wr_resp   = 1'b1;
          state_nxt = S_WRESP;
        end else begin
          rd_resp   = 1'b1;
          state_nxt = S_RRESP;
        end
      end
      S_WRESP: state_nxt = S_DONE;
      S_RRESP: begin
        if (BUS_rready) begin
          rd_accept = 1'b1;
          state_nxt = S_DONE;
        end
      end
      // Holding here until valid drops keeps one request from executing twice.
      S_DONE: begin
        if (!BUS_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mode_q     <= 1'b0;
      BUS_wready <= 1'b0;
      BUS_rvalid <= 1'b0;
      BUS_rdata  <= '0;
      oor_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (latch) begin
        addr_q  <= BUS_addr[31:2];
        wdata_q <= BUS_wdata;
        mode_q  <= BUS_mode;
      end
      BUS_wready <= wr_resp;
      if (rd_resp) begin
        BUS_rvalid <= 1'b1;
        BUS_rdata  <= in_range ? mem[idx] : 32'h0000_0000;
      end else if (rd_accept) begin
        BUS_rvalid <= 1'b0;
      end
      if ((wr_resp || rd_resp) && !in_range) oor_err <= 1'b1;
    end
  end

  // RAM has no reset so contents survive rst; wr_resp is low whenever rst holds state in IDLE.
  always_ff @(posedge clk) begin
    if (wr_resp && in_range) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - directed bench for bus_mem_responder with a per-cycle model compare
// Instance 0 runs with two wait states, instance 1 with none.
`timescale 1ns/1ps
module tb_bus_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [1:0][31:0] b_addr, b_wdata;
  logic [1:0]       b_mode, b_valid, b_rready;
  wire  [1:0]       b_wready, b_rvalid, b_oor;
  wire  [1:0][31:0] b_rdata;

  always #5 clk = ~clk;

  bus_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst),
    .BUS_addr(b_addr[0]), .BUS_wdata(b_wdata[0]), .BUS_mode(b_mode[0]),
    .BUS_valid(b_valid[0]), .BUS_wready(b_wready[0]), .BUS_rvalid(b_rvalid[0]),
    .BUS_rready(b_rready[0]), .BUS_rdata(b_rdata[0]), .oor_err(b_oor[0])
  );

  bus_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst),
    .BUS_addr(b_addr[1]), .BUS_wdata(b_wdata[1]), .BUS_mode(b_mode[1]),
    .BUS_valid(b_valid[1]), .BUS_wready(b_wready[1]), .BUS_rvalid(b_rvalid[1]),
    .BUS_rready(b_rready[1]), .BUS_rdata(b_rdata[1]), .oor_err(b_oor[1])
  );

  // Model: per-instance memory image and the outputs expected after each edge.
  logic [31:0]      mm [2][1024];
  logic [1:0]       ew, ev, eo;
  logic [1:0][31:0] ed;
  logic             cmp_en = 1'b0;
  logic [1:0]       prev_resp = 2'b00;
  int               n_tests = 0, n_fail = 0;
  int               cyc = 0;
  int               acc_cyc [2];
  int               resp_cyc [2];

  function automatic int wc(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic inr(logic [31:0] a);
    return a < 32'h0000_1000;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ((b_wready[d] | b_rvalid[d]) && !prev_resp[d]) resp_cyc[d] = cyc;
      prev_resp[d] = b_wready[d] | b_rvalid[d];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("wready%0d@%0d", k, cyc), {31'b0, b_wready[k]}, {31'b0, ew[k]});
        check($sformatf("rvalid%0d@%0d", k, cyc), {31'b0, b_rvalid[k]}, {31'b0, ev[k]});
        check($sformatf("rdata%0d@%0d", k, cyc), b_rdata[k], ed[k]);
        check($sformatf("oor%0d@%0d", k, cyc), {31'b0, b_oor[k]}, {31'b0, eo[k]});
      end
    end
  end

  task automatic do_write(int d, logic [31:0] a, logic [31:0] data, int hold);
    b_addr[d] = a; b_wdata[d] = data; b_mode[d] = 1'b1; b_valid[d] = 1'b1;
    @(posedge clk); #1;
    acc_cyc[d] = cyc;
    b_addr[d] = ~a; b_wdata[d] = ~data;
    repeat (wc(d) + 1) @(posedge clk);
    #1;
    ew[d] = 1'b1;
    if (inr(a)) mm[d][a[11:2]] = data;
    else eo[d] = 1'b1;
    @(posedge clk); #1;
    ew[d] = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    b_valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(int d, logic [31:0] a, int delay, output logic [31:0] rd);
    b_addr[d] = a; b_mode[d] = 1'b0; b_valid[d] = 1'b1; b_rready[d] = 1'b0;
    @(posedge clk); #1;
    acc_cyc[d] = cyc;
    b_addr[d] = ~a;
    repeat (wc(d) + 1) @(posedge clk);
    #1;
    ev[d] = 1'b1;
    ed[d] = inr(a) ? mm[d][a[11:2]] : 32'h0;
    if (!inr(a)) eo[d] = 1'b1;
    repeat (delay) begin @(posedge clk); #1; end
    rd = b_rdata[d];
    b_rready[d] = 1'b1;
    @(posedge clk); #1;
    ev[d] = 1'b0;
    b_rready[d] = 1'b0;
    b_valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int          r0;
    b_addr = '0; b_wdata = '0; b_mode = '0; b_valid = '0; b_rready = '0;
    ew = '0; ev = '0; eo = '0; ed = '0;
    #2 rst = 1'b1;
    #10;
    for (int d = 0; d < 2; d++) begin
      check("reset_wready", {31'b0, b_wready[d]}, 32'h0);
      check("reset_rvalid", {31'b0, b_rvalid[d]}, 32'h0);
      check("reset_rdata", b_rdata[d], 32'h0);
      check("reset_oor", {31'b0, b_oor[d]}, 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    // Two wait states: write/read latency, byte-offset aliasing, backpressure.
    do_write(0, 32'h10, 32'hA5A5_1234, 0);
    check("w2_write_latency", resp_cyc[0] - acc_cyc[0], 3);
    do_read(0, 32'h10, 0, r);
    check("w2_read_latency", resp_cyc[0] - acc_cyc[0], 3);
    check("w2_read_data", r, 32'hA5A5_1234);
    do_read(0, 32'h13, 5, r);
    check("backpressure_data", r, 32'hA5A5_1234);

    // Abort during WAIT leaves the earlier value in place.
    do_write(0, 32'h20, 32'h1111_2222, 0);
    r0 = resp_cyc[0];
    b_addr[0] = 32'h20; b_wdata[0] = 32'h0000_DEAD; b_mode[0] = 1'b1; b_valid[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_response", resp_cyc[0], r0);
    do_read(0, 32'h20, 1, r);
    check("abort_prior_value", r, 32'h1111_2222);

    // Zero wait states, valid held high through DONE.
    do_write(1, 32'h0, 32'h0000_0001, 4);
    check("w0_write_latency", resp_cyc[1] - acc_cyc[1], 1);
    do_read(1, 32'h0, 0, r);
    check("w0_read_latency", resp_cyc[1] - acc_cyc[1], 1);
    check("w0_read_data", r, 32'h0000_0001);

    // Out of range.
    do_write(1, 32'h1000, 32'hFFFF_FFFF, 0);
    check("oor_after_write", {31'b0, b_oor[1]}, 32'h1);
    do_read(1, 32'h1000, 0, r);
    check("oor_read_zero", r, 32'h0);
    do_read(1, 32'h0, 0, r);
    check("oor_word0_intact", r, 32'h0000_0001);
    check("oor_sticky", {31'b0, b_oor[1]}, 32'h1);

    // Async reset while a read sits in RRESP.
    b_addr[0] = 32'h10; b_mode[0] = 1'b0; b_valid[0] = 1'b1; b_rready[0] = 1'b0;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    ev[0] = 1'b1;
    ed[0] = mm[0][4];
    @(posedge clk); #3;
    rst = 1'b1;
    ew = '0; ev = '0; eo = '0; ed = '0;
    b_valid[0] = 1'b0;
    #1;
    check("async_rst_rvalid", {31'b0, b_rvalid[0]}, 32'h0);
    check("async_rst_rdata", b_rdata[0], 32'h0);
    check("async_rst_oor_clear", {31'b0, b_oor[1]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(0, 32'h10, 0, r);
    check("post_rst_data0", r, 32'hA5A5_1234);
    do_read(1, 32'h0, 0, r);
    check("post_rst_data1", r, 32'h0000_0001);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
